// File: rtl/fnd_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-aligned double buffering.
// Optional leading-zero blanking: define FND_LZB_EN.
module fnd_scan_driver #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DIGIT_DIV  = 100000,
    parameter int unsigned BLANK_CYC  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_load,
    output logic                    o_pending,
    output logic                    o_frame_start,
    output logic [2:0]              o_digit_sel,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic [6:0]              o_seg,
    output logic                    o_dp
);
    localparam int unsigned CNT_W = $clog2(DIGIT_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       SEL_LAST  = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        div_cnt;
    logic [2:0]              digit_sel;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic                    slot_end;
    logic                    frame_end;
    logic                    in_blank;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [3:0]              cur_val;
    logic                    cur_dp;
    logic                    lzb_hide;

    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] seg;
        unique case (val)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign slot_end    = (div_cnt == CNT_LAST);
    assign frame_end   = slot_end && (digit_sel == SEL_LAST);
    assign in_blank    = (div_cnt < CNT_BLANK);
    assign o_digit_sel = digit_sel;

`ifdef FND_LZB_EN
    // lead_zero[k]: digits k..NUM_DIGITS-1 are all zero with no decimal point.
    logic [NUM_DIGITS-1:0] lead_zero;
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            run          = run && (disp_data[4*k +: 4] == 4'd0) && !disp_dp[k];
            lead_zero[k] = run;
        end
    end
`endif

    always_comb begin
        an_sel   = '0;
        cur_val  = 4'd0;
        cur_dp   = 1'b0;
        lzb_hide = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (digit_sel == 3'(k)) begin
                an_sel[k] = 1'b1;
                cur_val   = disp_data[4*k +: 4];
                cur_dp    = disp_dp[k];
`ifdef FND_LZB_EN
                lzb_hide  = (k != 0) && lead_zero[k];
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_cnt       <= '0;
            digit_sel     <= 3'd0;
            shadow_data   <= '0;
            shadow_dp     <= '0;
            disp_data     <= '0;
            disp_dp       <= '0;
            o_pending     <= 1'b0;
            o_frame_start <= 1'b0;
            o_an          <= '1;
            o_seg         <= 7'h7F;
            o_dp          <= 1'b1;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + CNT_W'(1);
            if (slot_end) begin
                digit_sel <= (digit_sel == SEL_LAST) ? 3'd0 : digit_sel + 3'd1;
            end

            if (i_load) begin
                shadow_data <= i_data;
                shadow_dp   <= i_dp;
            end

            // A load on the boundary bypasses the shadow so it is never left pending.
            if (frame_end) begin
                if (i_load) begin
                    disp_data <= i_data;
                    disp_dp   <= i_dp;
                end else if (o_pending) begin
                    disp_data <= shadow_data;
                    disp_dp   <= shadow_dp;
                end
                o_pending <= 1'b0;
            end else if (i_load) begin
                o_pending <= 1'b1;
            end

            o_frame_start <= frame_end;

            if (in_blank || lzb_hide) begin
                o_an  <= '1;
                o_seg <= 7'h7F;
                o_dp  <= 1'b1;
            end else begin
                o_an  <= ~an_sel;
                o_seg <= seg_decode(cur_val);
                o_dp  <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver: frame-level reference model plus directed spot checks.
module tb_fnd_scan_driver;
    localparam int N = 4;
    localparam int D = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_data;
    logic [3:0]  i_dp;
    logic        i_load;
    logic        o_pending;
    logic        o_frame_start;
    logic [2:0]  o_digit_sel;
    logic [3:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;

    always #5 clk = ~clk;

    fnd_scan_driver #(
        .NUM_DIGITS(N),
        .DIGIT_DIV (D),
        .BLANK_CYC (B)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_dp         (i_dp),
        .i_load       (i_load),
        .o_pending    (o_pending),
        .o_frame_start(o_frame_start),
        .o_digit_sel  (o_digit_sel),
        .o_an         (o_an),
        .o_seg        (o_seg),
        .o_dp         (o_dp)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic       pend;
        logic       fs;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    logic [6:0] seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: ticks since reset, shown and buffered contents.
    int          m_t;
    logic [15:0] m_disp;
    logic [3:0]  m_ddp;
    logic [15:0] m_sh;
    logic [3:0]  m_shdp;
    logic        m_pend;

    function automatic bit lz_hidden(input int sel, input logic [15:0] disp, input logic [3:0] dp);
`ifdef FND_LZB_EN
        if (sel == 0) return 1'b0;
        for (int k = sel; k < N; k++) begin
            if (disp[4*k +: 4] != 4'd0 || dp[k]) return 1'b0;
        end
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        obs_t e;
        int   cnt;
        int   sel;
        bit   bnd;
        m_t = 0; m_disp = '0; m_ddp = '0; m_sh = '0; m_shdp = '0; m_pend = 1'b0;
        forever begin
            @(posedge clk);
            if (i_reset) begin
                m_t = 0; m_disp = '0; m_ddp = '0; m_sh = '0; m_shdp = '0; m_pend = 1'b0;
                e = '{sel: 3'd0, pend: 1'b0, fs: 1'b0, an: 4'hF, seg: 7'h7F, dp: 1'b1};
            end else begin
                cnt = m_t % D;
                sel = (m_t / D) % N;
                bnd = (m_t % (D * N)) == (D * N - 1);
                if (cnt < B || lz_hidden(sel, m_disp, m_ddp)) begin
                    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
                end else begin
                    e.an = 4'hF;
                    e.an[sel] = 1'b0;
                    e.seg = seg_tab[m_disp[4*sel +: 4]];
                    e.dp = ~m_ddp[sel];
                end
                if (bnd) begin
                    if (i_load) begin
                        m_disp = i_data; m_ddp = i_dp;
                    end else if (m_pend) begin
                        m_disp = m_sh; m_ddp = m_shdp;
                    end
                    m_pend = 1'b0;
                end else if (i_load) begin
                    m_sh = i_data; m_shdp = i_dp; m_pend = 1'b1;
                end
                m_t++;
                e.fs   = bnd;
                e.pend = m_pend;
                e.sel  = 3'((m_t / D) % N);
            end
            exp_q.push_back(e);
        end
    end

    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {o_digit_sel, o_pending, o_frame_start, o_an, o_seg, o_dp};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard @%0d: got sel=%0d pend=%b fs=%b an=%b seg=%h dp=%b, required sel=%0d pend=%b fs=%b an=%b seg=%h dp=%b",
                             cyc, a.sel, a.pend, a.fs, a.an, a.seg, a.dp,
                             e.sel, e.pend, e.fs, e.an, e.seg, e.dp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 80; i++) begin
            step();
            if (o_frame_start) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_frame: got no frame start within 80 cycles, required one");
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        i_load = 1'b1; i_data = d; i_dp = p;
        step();
        i_load = 1'b0;
    endtask

    logic [3:0] cap_an[32];
    logic [6:0] cap_seg[32];
    logic       cap_dp[32];
    logic [2:0] cap_sel[33];
    logic       cap_fs[33];

    // Index 0 is the current (frame-start) cycle; ends on the frame-boundary cycle.
    task automatic capture_frame();
        for (int i = 0; i < 32; i++) begin
            if (i > 0) step();
            cap_an[i] = o_an; cap_seg[i] = o_seg; cap_dp[i] = o_dp;
        end
    endtask

    initial begin
        i_reset = 1'b1; i_load = 1'b0; i_data = '0; i_dp = '0;
        repeat (3) step();
        chk("reset an", 32'(o_an), 32'hF);
        chk("reset seg", 32'(o_seg), 32'h7F);
        chk("reset dp", 32'(o_dp), 32'h1);
        chk("reset pending", 32'(o_pending), 32'h0);
        i_reset = 1'b0;

        for (int i = 0; i < 33; i++) begin
            if (i > 0) step();
            cap_sel[i] = o_digit_sel; cap_fs[i] = o_frame_start;
        end
        chk("sel start", 32'(cap_sel[0]), 32'd0);
        chk("sel slot0 end", 32'(cap_sel[7]), 32'd0);
        chk("sel slot1", 32'(cap_sel[8]), 32'd1);
        chk("sel slot2", 32'(cap_sel[16]), 32'd2);
        chk("sel slot3 end", 32'(cap_sel[31]), 32'd3);
        chk("sel wrap", 32'(cap_sel[32]), 32'd0);
        chk("no fs after reset", 32'(cap_fs[0]), 32'd0);
        chk("fs on wrap", 32'(cap_fs[32]), 32'd1);

        // Load mid-frame, shown from the next frame.
        repeat (5) step();
        load(16'h1250, 4'b0100);
        chk("s2 pending set", 32'(o_pending), 32'd1);
        wait_frame();
        chk("s2 pending clear", 32'(o_pending), 32'd0);
        capture_frame();
        chk("s2 blank0", 32'(cap_an[1]), 32'hF);
        chk("s2 blank1", 32'(cap_an[2]), 32'hF);
        chk("s2 d0 an", 32'(cap_an[3]), 32'hE);
        chk("s2 d0 seg", 32'(cap_seg[3]), 32'h40);
        chk("s2 d0 dp", 32'(cap_dp[3]), 32'h1);
        chk("s2 d1 blank", 32'(cap_an[10]), 32'hF);
        chk("s2 d1 seg", 32'(cap_seg[11]), 32'h12);
        chk("s2 d2 seg", 32'(cap_seg[19]), 32'h24);
        chk("s2 d2 dp", 32'(cap_dp[19]), 32'h0);
        chk("s2 d3 an", 32'(cap_an[27]), 32'h7);
        chk("s2 d3 seg", 32'(cap_seg[27]), 32'h79);

        // Two loads before the boundary: the last write wins.
        wait_frame();
        repeat (3) step();
        load(16'h1111, 4'b0000);
        step();
        load(16'h2222, 4'b0000);
        chk("s3 pending", 32'(o_pending), 32'd1);
        wait_frame();
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s3 d%0d seg", k), 32'(cap_seg[8*k+3]), 32'h24);
        end

        // Load exactly on the boundary cycle goes straight to display.
        wait_frame();
        repeat (31) step();
        load(16'hABCD, 4'b0000);
        chk("s4 fs", 32'(o_frame_start), 32'd1);
        chk("s4 pending", 32'(o_pending), 32'd0);
        capture_frame();
        chk("s4 d0 seg", 32'(cap_seg[3]), 32'h21);
        chk("s4 d1 seg", 32'(cap_seg[11]), 32'h46);
        chk("s4 d2 seg", 32'(cap_seg[19]), 32'h03);
        chk("s4 d3 seg", 32'(cap_seg[27]), 32'h08);
        chk("s4 pending end", 32'(o_pending), 32'd0);

        // Reset mid-slot of digit 2 clears display.
        wait_frame();
        repeat (20) step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("s5 an", 32'(o_an), 32'hF);
        chk("s5 seg", 32'(o_seg), 32'h7F);
        chk("s5 sel", 32'(o_digit_sel), 32'd0);
        repeat (3) step();
        chk("s5 d0 an", 32'(o_an), 32'hE);
        chk("s5 d0 seg", 32'(o_seg), 32'h40);

`ifdef FND_LZB_EN
        load(16'h0007, 4'b0000);
        wait_frame();
        capture_frame();
        chk("lzb d0 seg", 32'(cap_seg[3]), 32'h78);
        chk("lzb d1 an", 32'(cap_an[11]), 32'hF);
        chk("lzb d2 an", 32'(cap_an[19]), 32'hF);
        chk("lzb d3 an", 32'(cap_an[27]), 32'hF);
        step();
        load(16'h0007, 4'b0100);
        wait_frame();
        capture_frame();
        chk("lzb dp d1 an", 32'(cap_an[11]), 32'hD);
        chk("lzb dp d2 an", 32'(cap_an[19]), 32'hB);
        chk("lzb dp d2 dp", 32'(cap_dp[19]), 32'h0);
        chk("lzb dp d3 an", 32'(cap_an[27]), 32'hF);
`endif

        for (int i = 0; i < 800; i++) begin
            i_load  = ($urandom_range(0, 11) == 0);
            i_data  = 16'($urandom);
            i_dp    = 4'($urandom_range(0, 15));
            i_reset = ($urandom_range(0, 299) == 0);
            step();
        end
        i_load = 1'b0; i_reset = 1'b0;
        repeat (4) step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
